shift_add_mult_sched: RTL

//   Two-requester scheduler and sequencer for one shared shift-and-add multiplier.

---
 rtl/shift_add_mult_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_add_mult_sched.sv
// -----------------------------------------------------------------------------
// shift_add_mult_sched
//   Two-requester round-robin scheduler in front of one shared shift-and-add
//   multiplier. One multiplier bit is consumed per RUN cycle:
//   acc += a_sh when b_sh[0] is set, then a_sh shifts left and b_sh shifts right.
//   The product is returned with a one-cycle done pulse and the owner's id.
//
//   Optional build macro: EARLY_TERM_EN
//     When defined, RUN ends as soon as the remaining multiplier bits are all
//     zero, so latency follows the MSB set in B (B=0 takes one RUN edge).
//     When undefined, every operation takes exactly N RUN edges.
// -----------------------------------------------------------------------------
module shift_add_mult_sched #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [M-1:0]     a0,
    input  logic [N-1:0]     b0,
    input  logic             req1,
    input  logic [M-1:0]     a1,
    input  logic [N-1:0]     b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [M+N-1:0]   product
);

    localparam int P  = M + N;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifndef EARLY_TERM_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Zero-extend a multiplicand to the full product width.
    function automatic logic [P-1:0] zext_a(input logic [M-1:0] a);
        return {{N{1'b0}}, a};
    endfunction

    state_t          state_r,   state_s;
    logic [P-1:0]    a_sh_r,    a_sh_s;
    logic [N-1:0]    b_sh_r,    b_sh_s;
    logic [P-1:0]    acc_r,     acc_s;
    logic [CW-1:0]   cnt_r,     cnt_s;
    logic            last_id_r, last_id_s;
    logic            owner_r,   owner_s;
    logic            gnt0_r,    gnt0_s;
    logic            gnt1_r,    gnt1_s;
    logic            busy_r,    busy_s;
    logic            done_r,    done_s;
    logic            done_id_r, done_id_s;
    logic [P-1:0]    product_r, product_s;

    logic            win_s;
    logic [P-1:0]    sum_s;
    logic [N-1:0]    b_nx_s;
    logic            finish_s;

    // Round-robin arbitration: a tie goes to the requester not served last.
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_id_r;
        end else if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end

    // One shift-and-add step and the end-of-run decision for this edge.
    always_comb begin
        sum_s  = acc_r + (b_sh_r[0] ? a_sh_r : {P{1'b0}});
        b_nx_s = {1'b0, b_sh_r[N-1:1]};
`ifdef EARLY_TERM_EN
        finish_s = (b_nx_s == {N{1'b0}});
`else
        finish_s = (cnt_r == CNT_LAST);
`endif
    end

    // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_s   = state_r;
        a_sh_s    = a_sh_r;
        b_sh_s    = b_sh_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        last_id_s = last_id_r;
        owner_s   = owner_r;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        done_id_s = done_id_r;
        product_s = product_r;

        case (state_r)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Operands are captured here; later input changes are ignored.
                    a_sh_s    = win_s ? zext_a(a1) : zext_a(a0);
                    b_sh_s    = win_s ? b1 : b0;
                    acc_s     = {P{1'b0}};
                    cnt_s     = {CW{1'b0}};
                    last_id_s = win_s;
                    owner_s   = win_s;
                    gnt0_s    = ~win_s;
                    gnt1_s    = win_s;
                    busy_s    = 1'b1;
                    state_s   = S_RUN;
                end else begin
                    busy_s    = 1'b0;
                    state_s   = S_IDLE;
                end
            end
            S_RUN: begin
                acc_s  = sum_s;
                a_sh_s = {a_sh_r[P-2:0], 1'b0};
                b_sh_s = b_nx_s;
                cnt_s  = cnt_r + CNT_ONE;
                busy_s = 1'b1;
                if (finish_s) begin
                    // sum_s already includes this edge's partial product.
                    product_s = sum_s;
                    done_s    = 1'b1;
                    done_id_s = owner_r;
                    state_s   = S_DONE;
                end else begin
                    state_s   = S_RUN;
                end
            end
            S_DONE: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh_r    <= {P{1'b0}};
            b_sh_r    <= {N{1'b0}};
            acc_r     <= {P{1'b0}};
            cnt_r     <= {CW{1'b0}};
            last_id_r <= 1'b1;
            owner_r   <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            product_r <= {P{1'b0}};
        end else begin
            a_sh_r    <= a_sh_s;
            b_sh_r    <= b_sh_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            last_id_r <= last_id_s;
            owner_r   <= owner_s;
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            done_id_r <= done_id_s;
            product_r <= product_s;
        end
    end

    assign gnt0    = gnt0_r;
    assign gnt1    = gnt1_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign product = product_r;

endmodule
